// File: rtl/move_executor_if.sv
// Move-command bus between the solver (master) and the move executor (slave).
// Carries board load, the move command and all executor status outputs.
interface move_executor_if #(
    parameter int CNT_W = 16
);
    logic             i_load;
    logic [63:0]      i_klotski;
    logic             i_en;
    logic [3:0]       i_start_block;
    logic [3:0]       i_end_block;
    logic [3:0]       i_number;
    logic             o_continue;
    logic             o_busy;
    logic [63:0]      o_klotski;
    logic [CNT_W-1:0] o_move_count;
    logic             o_error;
    logic [3:0]       o_blank_pos;

    modport master (
        output i_load, i_klotski, i_en, i_start_block, i_end_block, i_number,
        input  o_continue, o_busy, o_klotski, o_move_count, o_error, o_blank_pos
    );

    modport slave (
        input  i_load, i_klotski, i_en, i_start_block, i_end_block, i_number,
        output o_continue, o_busy, o_klotski, o_move_count, o_error, o_blank_pos
    );
endinterface

// File: rtl/move_executor.sv
// Move executor: keeps its own copy of the 4x4 sliding-tile board, validates
// each move command from the solver, applies valid ones, holds the result for
// a display interval and then releases the solver with a one-cycle pulse.
// Invalid moves set a sticky error but still complete the handshake.
module move_executor #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input logic            i_clk,
    input logic            i_rst_n,
    move_executor_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    localparam logic [15:0]      HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [63:0]      board_q, board_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;
    logic [3:0]       blank_q, blank_d;
    logic [15:0]      hold_q, hold_d;
    logic [3:0]       start_q, start_d;
    logic [3:0]       dest_q, dest_d;
    logic [3:0]       num_q, num_d;
    logic             cont_q, cont_d;
    logic             busy_q, busy_d;

    logic [3:0] src_cell;
    logic [3:0] dst_cell;
    logic       row_step;
    logic       col_step;
    logic       move_ok;
    logic [3:0] load_blank;

    assign src_cell = board_q[{start_q, 2'b00} +: 4];
    assign dst_cell = board_q[{dest_q, 2'b00} +: 4];

    // Horizontal neighbours share a row and differ by one column; comparing
    // row/col fields separately rejects index +-1 wrapping across a row.
    assign col_step = (start_q[3:2] == dest_q[3:2]) &&
                      ((({1'b0, start_q[1:0]} + 3'd1) == {1'b0, dest_q[1:0]}) ||
                       (({1'b0, dest_q[1:0]} + 3'd1) == {1'b0, start_q[1:0]}));
    assign row_step = (start_q[1:0] == dest_q[1:0]) &&
                      ((({1'b0, start_q[3:2]} + 3'd1) == {1'b0, dest_q[3:2]}) ||
                       (({1'b0, dest_q[3:2]} + 3'd1) == {1'b0, start_q[3:2]}));

    assign move_ok = (start_q != dest_q) && (col_step || row_step) &&
                     (dst_cell == 4'h0) && (src_cell == num_q) && (num_q != 4'h0);

    // Blank position of an incoming board: lowest-indexed zero cell, 0 if none.
    always_comb begin
        load_blank = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (bus.i_klotski[4*i +: 4] == 4'h0) begin
                load_blank = 4'(i);
            end
        end
    end

    // Next-state logic: load overrides everything, otherwise step the move FSM.
    always_comb begin
        state_d = state_q;
        board_d = board_q;
        count_d = count_q;
        error_d = error_q;
        blank_d = blank_q;
        hold_d  = hold_q;
        start_d = start_q;
        dest_d  = dest_q;
        num_d   = num_q;
        busy_d  = (state_q != S_IDLE);
        cont_d  = (state_q == S_ACK);

        if (bus.i_load) begin
            board_d = bus.i_klotski;
            count_d = '0;
            error_d = 1'b0;
            blank_d = load_blank;
            hold_d  = 16'd0;
            state_d = S_IDLE;
            cont_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_en) begin
                        start_d = bus.i_start_block;
                        dest_d  = bus.i_end_block;
                        num_d   = bus.i_number;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (move_ok) begin
                        board_d[{dest_q, 2'b00} +: 4]  = num_q;
                        board_d[{start_q, 2'b00} +: 4] = 4'h0;
                        blank_d = start_q;
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + CNT_ONE;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                    hold_d  = 16'd0;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_ACK;
                    end else begin
                        hold_d = hold_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            board_q <= '0;
            count_q <= '0;
            error_q <= 1'b0;
            blank_q <= 4'h0;
            hold_q  <= 16'd0;
            start_q <= 4'h0;
            dest_q  <= 4'h0;
            num_q   <= 4'h0;
            cont_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            count_q <= count_d;
            error_q <= error_d;
            blank_q <= blank_d;
            hold_q  <= hold_d;
            start_q <= start_d;
            dest_q  <= dest_d;
            num_q   <= num_d;
            cont_q  <= cont_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.o_continue   = cont_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_klotski    = board_q;
    assign bus.o_move_count = count_q;
    assign bus.o_error      = error_q;
    assign bus.o_blank_pos  = blank_q;
endmodule

// File: tb/tb_move_executor.sv
// Testbench for move_executor: a board model tracks expected results, each
// issued move pushes its expected outcome, and a monitor compares on o_continue.
module tb_move_executor;
    localparam int HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    move_executor_if #(.CNT_W(16)) bus ();
    move_executor_if #(.CNT_W(3))  bus2 ();

    move_executor #(.HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    move_executor #(.HOLD_CYCLES(1), .CNT_W(3)) dut_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus2)
    );

    // Free-running clock and edge counter used for latency checks.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] board;
        int          count;
        bit          err;
        int          blank;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [3:0] m_cells[16];
    int         m_count;
    bit         m_err;
    int         m_blank;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_pack();
        logic [63:0] b;
        for (int i = 0; i < 16; i++) b[4*i +: 4] = m_cells[i];
        return b;
    endfunction

    function automatic logic [63:0] solved_board();
        logic [63:0] b;
        for (int i = 0; i < 15; i++) b[4*i +: 4] = 4'(i + 1);
        b[60 +: 4] = 4'h0;
        return b;
    endfunction

    function automatic void m_load(input logic [63:0] b);
        for (int i = 0; i < 16; i++) m_cells[i] = b[4*i +: 4];
        m_count = 0;
        m_err   = 1'b0;
        m_blank = 0;
        for (int i = 15; i >= 0; i--) if (m_cells[i] == 4'h0) m_blank = i;
    endfunction

    // Apply the sliding-puzzle rules to the model board.
    function automatic void m_move(input int s, input int e, input int n);
        int  sr = s / 4, sc = s % 4, er = e / 4, ec = e % 4;
        bit  adj;
        adj = (sr == er && (sc - ec == 1 || ec - sc == 1)) ||
              (sc == ec && (sr - er == 1 || er - sr == 1));
        if (s != e && adj && m_cells[e] == 4'h0 && int'(m_cells[s]) == n && n != 0) begin
            m_cells[e] = 4'(n);
            m_cells[s] = 4'h0;
            m_blank    = s;
            if (m_count < 65535) m_count++;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    // Monitor: every o_continue pulse must match the oldest expected move.
    always @(negedge clk) begin
        if (rst_n && bus.o_continue) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_continue: got 1 expected 0");
            end else begin
                mon_e = sb.pop_front();
                check("ack_board", bus.o_klotski, mon_e.board);
                check("ack_count", 64'(bus.o_move_count), 64'(mon_e.count));
                check("ack_error", 64'(bus.o_error), 64'(mon_e.err));
                check("ack_blank", 64'(bus.o_blank_pos), 64'(mon_e.blank));
                check("ack_busy", 64'(bus.o_busy), 64'd1);
                check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic do_load(input logic [63:0] b, input bit with_en);
        @(posedge clk); #1;
        bus.i_load    = 1'b1;
        bus.i_klotski = b;
        if (with_en) begin
            bus.i_en          = 1'b1;
            bus.i_start_block = 4'd5;
            bus.i_end_block   = 4'd4;
            bus.i_number      = 4'd6;
        end
        @(posedge clk); #1;
        bus.i_load = 1'b0;
        bus.i_en   = 1'b0;
        m_load(b);
        sb.delete();
        @(negedge clk);
        check("load_board", bus.o_klotski, b);
        check("load_count", 64'(bus.o_move_count), 64'd0);
        check("load_error", 64'(bus.o_error), 64'd0);
        check("load_busy", 64'(bus.o_busy), 64'd0);
        check("load_blank", 64'(bus.o_blank_pos), 64'(m_blank));
        check("load_continue", 64'(bus.o_continue), 64'd0);
    endtask

    task automatic apply_stimulus(input int s, input int e, input int n, input bit spam);
        bit seen;
        @(posedge clk); #1;
        bus.i_en          = 1'b1;
        bus.i_start_block = 4'(s);
        bus.i_end_block   = 4'(e);
        bus.i_number      = 4'(n);
        m_move(s, e, n);
        sb.push_back('{board: m_pack(), count: m_count, err: m_err,
                       blank: m_blank, cyc: cyc + 1 + 2 + HOLD});
        @(posedge clk); #1;
        bus.i_en = 1'b0;
        @(posedge clk);
        if (spam) begin
            #1;
            bus.i_en          = 1'b1;
            bus.i_start_block = 4'($urandom_range(0, 15));
            bus.i_end_block   = 4'($urandom_range(0, 15));
            bus.i_number      = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        check("edge1_board", bus.o_klotski, m_pack());
        check("edge1_count", 64'(bus.o_move_count), 64'(m_count));
        check("edge1_blank", 64'(bus.o_blank_pos), 64'(m_blank));
        check("edge1_busy", 64'(bus.o_busy), 64'd1);
        @(posedge clk); #1;
        bus.i_en = 1'b0;
        if (spam) begin
            @(posedge clk); #1;
            bus.i_en = 1'b1;
            @(posedge clk); #1;
            bus.i_en = 1'b0;
        end
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge clk);
            if (bus.o_continue) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL continue_timeout: got none expected pulse");
        end
        @(negedge clk);
        check("post_ack_busy", 64'(bus.o_busy), 64'd0);
        check("post_ack_continue", 64'(bus.o_continue), 64'd0);
    endtask

    task automatic random_move();
        int b, br, bc, s, d;
        b  = m_blank;
        br = b / 4;
        bc = b % 4;
        s  = -1;
        while (s < 0) begin
            d = $urandom_range(0, 3);
            case (d)
                0: if (br > 0) s = b - 4;
                1: if (br < 3) s = b + 4;
                2: if (bc > 0) s = b - 1;
                default: if (bc < 3) s = b + 1;
            endcase
        end
        apply_stimulus(s, b, int'(m_cells[s]), $urandom_range(0, 9) == 0);
    endtask

    // Narrow-counter instance: ten valid moves must clamp at 7.
    task automatic sat_test();
        bit seen;
        @(posedge clk); #1;
        bus2.i_load    = 1'b1;
        bus2.i_klotski = solved_board();
        @(posedge clk); #1;
        bus2.i_load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            bus2.i_en          = 1'b1;
            bus2.i_start_block = (k % 2 == 1) ? 4'd14 : 4'd15;
            bus2.i_end_block   = (k % 2 == 1) ? 4'd15 : 4'd14;
            bus2.i_number      = 4'd15;
            @(posedge clk); #1;
            bus2.i_en = 1'b0;
            seen = 1'b0;
            for (int t = 0; t < 20 && !seen; t++) begin
                @(negedge clk);
                if (bus2.o_continue) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("[TB] FAIL sat_timeout: got none expected pulse");
            end
            check("sat_count", 64'(bus2.o_move_count), 64'((k < 7) ? k : 7));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [63:0] wrap_b;
        logic [63:0] two_zero_b;
        int          r;
        bus.i_load = 0; bus.i_klotski = '0; bus.i_en = 0;
        bus.i_start_block = 0; bus.i_end_block = 0; bus.i_number = 0;
        bus2.i_load = 0; bus2.i_klotski = '0; bus2.i_en = 0;
        bus2.i_start_block = 0; bus2.i_end_block = 0; bus2.i_number = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_board", bus.o_klotski, 64'd0);
        check("reset_count", 64'(bus.o_move_count), 64'd0);
        check("reset_busy", 64'(bus.o_busy), 64'd0);
        check("reset_error", 64'(bus.o_error), 64'd0);
        check("reset_blank", 64'(bus.o_blank_pos), 64'd0);
        check("reset_continue", 64'(bus.o_continue), 64'd0);
        rst_n = 1'b1;

        do_load(solved_board(), 1'b0);
        apply_stimulus(14, 15, 15, 1'b0);

        wrap_b = solved_board();
        wrap_b[16 +: 4] = 4'h0;
        wrap_b[60 +: 4] = 4'h5;
        do_load(wrap_b, 1'b0);
        apply_stimulus(3, 4, 4, 1'b0);
        apply_stimulus(5, 4, 7, 1'b0);
        apply_stimulus(0, 1, 1, 1'b0);
        apply_stimulus(5, 4, 6, 1'b1);

        // Load arriving mid-HOLD aborts the in-flight move.
        @(posedge clk); #1;
        bus.i_en = 1'b1; bus.i_start_block = 4'd4; bus.i_end_block = 4'd5; bus.i_number = 4'd6;
        @(posedge clk); #1;
        bus.i_en = 1'b0;
        @(posedge clk); #1;
        do_load(solved_board(), 1'b0);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("no_continue_after_load", 64'(bus.o_continue), 64'd0);
        end

        do_load(wrap_b, 1'b1);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            check("load_beats_en", 64'(bus.o_continue), 64'd0);
        end

        two_zero_b = solved_board();
        two_zero_b[8 +: 4] = 4'h0;
        do_load(two_zero_b, 1'b0);
        do_load(64'h1111_2222_3333_4444, 1'b0);
        apply_stimulus(1, 0, 1, 1'b0);

        // Asynchronous reset in the middle of HOLD.
        do_load(solved_board(), 1'b0);
        @(posedge clk); #1;
        bus.i_en = 1'b1; bus.i_start_block = 4'd11; bus.i_end_block = 4'd15; bus.i_number = 4'd12;
        @(posedge clk); #1;
        bus.i_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_board", bus.o_klotski, 64'd0);
        check("arst_count", 64'(bus.o_move_count), 64'd0);
        check("arst_busy", 64'(bus.o_busy), 64'd0);
        check("arst_error", 64'(bus.o_error), 64'd0);
        check("arst_blank", 64'(bus.o_blank_pos), 64'd0);
        check("arst_continue", 64'(bus.o_continue), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_load(solved_board(), 1'b0);
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                do_load(solved_board(), 1'b0);
            end else if (r < 75) begin
                random_move();
            end else begin
                apply_stimulus($urandom_range(0, 15), $urandom_range(0, 15),
                               $urandom_range(0, 15), 1'b0);
            end
        end

        sat_test();

        repeat (5) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends with a summary.
    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
